// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Shares one single-port, word-addressed data memory between requester A
//   (core load/store) and requester B (DMA / float side port). Round-robin on
//   ties, with an optional lock so one side can hold the memory for an atomic
//   read-modify-write. A lock that outlives LOCK_MAX cycles is forcibly
//   released and flagged with a one-cycle lock_timeout pulse.
//
// Ports
//   clk, reset               system clock, synchronous active-low reset
//   a_* / b_*                per-requester request, payload, grant and
//                            registered read response (rvalid pulse + rdata)
//   mem_*                    combinational drive to / read data from memory
//   lock_timeout             one-cycle pulse after a forced lock release
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; single requester wins, ties go to non-last-winner
// LOCKED_A | A owns the memory; only A may be granted
// LOCKED_B | B owns the memory; only B may be granted
module datamem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              lock_timeout
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  // Down-counter loaded on lock entry; reaching zero marks the last
  // permitted locked cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED_A = 2'd1,
    LOCKED_B = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_b, last_b_nxt;   // 1 = B won the most recent grant
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             timeout_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    last_b_nxt   = last_b;
    lock_cnt_nxt = lock_cnt;
    timeout_nxt  = 1'b0;
    if (a_gnt) last_b_nxt = 1'b0;
    else if (b_gnt) last_b_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (a_gnt && a_lock) begin
          state_nxt    = LOCKED_A;
          lock_cnt_nxt = CNT_LOAD;
        end else if (b_gnt && b_lock) begin
          state_nxt    = LOCKED_B;
          lock_cnt_nxt = CNT_LOAD;
        end
      end
      LOCKED_A: begin
        // A releasing grant takes priority over an expiring counter.
        if (a_gnt && !a_lock) begin
          state_nxt = IDLE;
        end else if (lock_cnt == '0) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          last_b_nxt  = 1'b0;
        end else begin
          lock_cnt_nxt = lock_cnt - 1'b1;
        end
      end
      LOCKED_B: begin
        if (b_gnt && !b_lock) begin
          state_nxt = IDLE;
        end else if (lock_cnt == '0) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          last_b_nxt  = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: grants and memory drive
  always_comb begin
    a_gnt            = 1'b0;
    b_gnt            = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (a_req && (!b_req || last_b)) a_gnt = 1'b1;
          else if (b_req)                  b_gnt = 1'b1;
        end
        LOCKED_A: a_gnt = a_req;
        LOCKED_B: b_gnt = b_req;
        default: ;
      endcase
    end
    if (a_gnt) begin
      mem_address      = a_addr;
      mem_write_data   = a_wdata;
      mem_write_enable = a_we;
      mem_read_enable  = ~a_we;
    end else if (b_gnt) begin
      mem_address      = b_addr;
      mem_write_data   = b_wdata;
      mem_write_enable = b_we;
      mem_read_enable  = ~b_we;
    end
  end

  // Read responses and timeout pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      lock_timeout <= 1'b0;
    end else begin
      a_rvalid     <= a_gnt & ~a_we;
      b_rvalid     <= b_gnt & ~b_we;
      lock_timeout <= timeout_nxt;
      if (a_gnt && !a_we) a_rdata <= mem_read_data;
      if (b_gnt && !b_we) b_rdata <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;
  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, lock_timeout;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  logic [15:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  datamem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .lock_timeout(lock_timeout)
  );

  // Bench-side data memory: combinational read, posedge write, plus a
  // preload port used while the arbiter is idle.
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  task automatic preload(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic lock);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_lock = lock;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic lock);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_lock = lock;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    set_a(1, 0, 16'h0001, 0, 0);
    set_b(1, 1, 16'h0002, 16'h5555, 0);
    #1;
    n_tests++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_a_gnt got %0b want 0", a_gnt); end
    n_tests++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_b_gnt got %0b want 0", b_gnt); end
    n_tests++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", mem_write_enable); end
    n_tests++; if (mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_re got %0b want 0", mem_read_enable); end
    @(negedge clk);
    #1;
    n_tests++; if ({a_rvalid, b_rvalid, lock_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {a_rvalid, b_rvalid, lock_timeout}); end
    n_tests++; if (a_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_a_rdata got %h want 0000", a_rdata); end
    n_tests++; if (b_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_b_rdata got %h want 0000", b_rdata); end
    @(negedge clk);
    reset = 1'b1;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
  endtask

  task automatic test_single_read();
    preload(16'h0010, 16'hBEEF);
    @(negedge clk);
    set_a(1, 0, 16'h0010, 0, 0);
    #1;
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL sr_a_gnt got %0b want 1", a_gnt); end
    n_tests++; if (mem_read_enable !== 1'b1 || mem_address !== 16'h0010) begin n_fail++; $display("FAIL sr_mem got re=%0b addr=%h want re=1 addr=0010", mem_read_enable, mem_address); end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    #1;
    n_tests++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL sr_a_rvalid got %0b want 1", a_rvalid); end
    n_tests++; if (a_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL sr_a_rdata got %h want beef", a_rdata); end
    n_tests++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_b_rvalid got %0b want 0", b_rvalid); end
    @(negedge clk);
    #1;
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_pulse_end got %0b want 0", a_rvalid); end
    n_tests++; if (a_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL sr_rdata_hold got %h want beef", a_rdata); end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    preload(16'h0001, 16'h1111);
    preload(16'h0002, 16'h2222);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_a(1, 0, 16'h0001, 0, 0);
    set_b(1, 0, 16'h0002, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_a = (i % 2 == 0);
      n_tests++; if (a_gnt !== exp_a) begin n_fail++; $display("FAIL rr_a_gnt[%0d] got %0b want %0b", i, a_gnt, exp_a); end
      n_tests++; if (b_gnt !== !exp_a) begin n_fail++; $display("FAIL rr_b_gnt[%0d] got %0b want %0b", i, b_gnt, !exp_a); end
      n_tests++; if (mem_address !== (exp_a ? 16'h0001 : 16'h0002)) begin n_fail++; $display("FAIL rr_addr[%0d] got %h", i, mem_address); end
      if (i > 0) begin
        n_tests++; if (a_rvalid !== !exp_a) begin n_fail++; $display("FAIL rr_a_rvalid[%0d] got %0b want %0b", i, a_rvalid, !exp_a); end
        n_tests++; if (b_rvalid !== exp_a) begin n_fail++; $display("FAIL rr_b_rvalid[%0d] got %0b want %0b", i, b_rvalid, exp_a); end
        if (!exp_a) begin
          n_tests++; if (a_rdata !== 16'h1111) begin n_fail++; $display("FAIL rr_a_rdata[%0d] got %h want 1111", i, a_rdata); end
        end else begin
          n_tests++; if (b_rdata !== 16'h2222) begin n_fail++; $display("FAIL rr_b_rdata[%0d] got %h want 2222", i, b_rdata); end
        end
      end
    end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_b(1, 1, 16'h00FF, 16'h1234, 0);
    #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_b_gnt got %0b want 1", b_gnt); end
    n_tests++; if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL wr_enables got we=%0b re=%0b want we=1 re=0", mem_write_enable, mem_read_enable); end
    n_tests++; if (mem_address !== 16'h00FF || mem_write_data !== 16'h1234) begin n_fail++; $display("FAIL wr_payload got %h/%h want 00ff/1234", mem_address, mem_write_data); end
    @(negedge clk);
    set_b(0, 0, 0, 0, 0);
    set_a(1, 0, 16'h00FF, 0, 0);
    #1;
    n_tests++; if (a_gnt !== 1'b1 || mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL wr_read_gnt got gnt=%0b we=%0b want gnt=1 we=0", a_gnt, mem_write_enable); end
    n_tests++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got %0b want 0", b_rvalid); end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    #1;
    n_tests++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin n_fail++; $display("FAIL wr_readback got v=%0b d=%h want v=1 d=1234", a_rvalid, a_rdata); end
  endtask

  task automatic test_lock_rmw();
    preload(16'h0020, 16'h0042);
    @(negedge clk);
    set_a(1, 0, 16'h0020, 0, 1);
    #1;
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL lk_a_gnt got %0b want 1", a_gnt); end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    set_b(1, 0, 16'h0030, 0, 0);
    #1;
    n_tests++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL lk_b_blocked got %0b want 0", b_gnt); end
    n_tests++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h0042) begin n_fail++; $display("FAIL lk_read got v=%0b d=%h want v=1 d=0042", a_rvalid, a_rdata); end
    @(negedge clk);
    set_a(1, 1, 16'h0020, 16'h0043, 0);
    #1;
    n_tests++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_fail++; $display("FAIL lk_write_gnt got a=%0b b=%0b want a=1 b=0", a_gnt, b_gnt); end
    n_tests++; if (mem_write_enable !== 1'b1 || mem_write_data !== 16'h0043) begin n_fail++; $display("FAIL lk_write got we=%0b d=%h want we=1 d=0043", mem_write_enable, mem_write_data); end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL lk_b_after got %0b want 1", b_gnt); end
    n_tests++; if (lock_timeout !== 1'b0) begin n_fail++; $display("FAIL lk_no_timeout got %0b want 0", lock_timeout); end
    @(negedge clk);
    set_b(0, 0, 0, 0, 0);
    #1;
    n_tests++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL lk_b_rvalid got %0b want 1", b_rvalid); end
  endtask

  task automatic test_timeout();
    logic exp;
    @(negedge clk);
    set_a(1, 0, 16'h0003, 0, 1);
    #1;
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL to_lock_gnt got %0b want 1", a_gnt); end
    for (int k = 1; k <= LOCK_MAX + 3; k++) begin
      @(negedge clk);
      set_a(0, 0, 0, 0, 0);
      set_b(k <= LOCK_MAX + 1, 0, 16'h0004, 0, 0);
      #1;
      exp = (k == LOCK_MAX + 1);
      n_tests++; if (lock_timeout !== exp) begin n_fail++; $display("FAIL to_pulse[%0d] got %0b want %0b", k, lock_timeout, exp); end
      n_tests++; if (b_gnt !== exp) begin n_fail++; $display("FAIL to_b_gnt[%0d] got %0b want %0b", k, b_gnt, exp); end
    end
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk);
    set_b(1, 0, 16'h0005, 0, 1);
    #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL rml_b_lock got %0b want 1", b_gnt); end
    @(negedge clk);
    reset = 1'b0;
    set_b(1, 0, 16'h0006, 0, 1);
    set_a(1, 0, 16'h0001, 0, 0);
    #1;
    n_tests++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_fail++; $display("FAIL rml_gnt_forced got a=%0b b=%0b want 0 0", a_gnt, b_gnt); end
    @(negedge clk);
    reset = 1'b1;
    set_b(1, 0, 16'h0002, 0, 0);
    #1;
    n_tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rml_no_rvalid got a=%0b b=%0b want 0 0", a_rvalid, b_rvalid); end
    n_tests++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_fail++; $display("FAIL rml_tie got a=%0b b=%0b want 1 0", a_gnt, b_gnt); end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    #1;
    n_tests++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h1111) begin n_fail++; $display("FAIL rml_a_read got v=%0b d=%h want v=1 d=1111", a_rvalid, a_rdata); end
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL rml_b_next got %0b want 1", b_gnt); end
    @(negedge clk);
    set_b(0, 0, 0, 0, 0);
    #1;
    n_tests++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h2222) begin n_fail++; $display("FAIL rml_b_read got v=%0b d=%h want v=1 d=2222", b_rvalid, b_rdata); end
  endtask

  // Random traffic against a transaction-level reference: who owns the
  // memory, how long the current lock has lasted, who won last, and a
  // shadow copy of the 16 words in play.
  task automatic test_random();
    int          owner, age, last, n_to;
    logic        ga, gb, ea_rv, eb_rv, e_to, a_done, b_done;
    logic [15:0] ea_rd, eb_rd, e_addr, e_wd;
    logic        e_we, e_re;
    logic [15:0] ref_mem [16];
    @(negedge clk);
    reset = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      preload(16'(i), ref_mem[i]);
    end
    owner = 0; age = 0; last = 1; n_to = 0;
    ea_rv = 0; eb_rv = 0; e_to = 0; ea_rd = 0; eb_rd = 0;
    a_done = 0; b_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (a_done) a_req = 1'b0;
      if (b_done) b_req = 1'b0;
      if (!a_req && $urandom_range(0, 2) != 0)
        set_a(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) == 0);
      if (!b_req && $urandom_range(0, 2) != 0)
        set_b(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) == 0);
      #1;
      ga = 0; gb = 0;
      if (owner == 1) ga = a_req;
      else if (owner == 2) gb = b_req;
      else if (a_req && b_req) begin
        if (last == 1) ga = 1; else gb = 1;
      end else begin
        ga = a_req; gb = b_req;
      end
      e_addr = ga ? a_addr : (gb ? b_addr : 16'h0);
      e_wd   = ga ? a_wdata : (gb ? b_wdata : 16'h0);
      e_we   = (ga && a_we) || (gb && b_we);
      e_re   = (ga && !a_we) || (gb && !b_we);
      n_tests++; if (a_gnt !== ga) begin n_fail++; $display("FAIL rnd_a_gnt @%0d got %0b want %0b", cyc, a_gnt, ga); end
      n_tests++; if (b_gnt !== gb) begin n_fail++; $display("FAIL rnd_b_gnt @%0d got %0b want %0b", cyc, b_gnt, gb); end
      n_tests++; if ({mem_write_enable, mem_read_enable} !== {e_we, e_re}) begin n_fail++; $display("FAIL rnd_en @%0d got %b want %b", cyc, {mem_write_enable, mem_read_enable}, {e_we, e_re}); end
      n_tests++; if (mem_address !== e_addr || mem_write_data !== e_wd) begin n_fail++; $display("FAIL rnd_payload @%0d got %h/%h want %h/%h", cyc, mem_address, mem_write_data, e_addr, e_wd); end
      n_tests++; if ({a_rvalid, b_rvalid} !== {ea_rv, eb_rv}) begin n_fail++; $display("FAIL rnd_rvalid @%0d got %b want %b", cyc, {a_rvalid, b_rvalid}, {ea_rv, eb_rv}); end
      n_tests++; if (a_rdata !== ea_rd || b_rdata !== eb_rd) begin n_fail++; $display("FAIL rnd_rdata @%0d got %h/%h want %h/%h", cyc, a_rdata, b_rdata, ea_rd, eb_rd); end
      n_tests++; if (lock_timeout !== e_to) begin n_fail++; $display("FAIL rnd_timeout @%0d got %0b want %0b", cyc, lock_timeout, e_to); end
      // advance reference to the state after this cycle's edge
      e_to  = 0;
      ea_rv = ga && !a_we;
      eb_rv = gb && !b_we;
      if (ea_rv) ea_rd = ref_mem[a_addr[3:0]];
      if (eb_rv) eb_rd = ref_mem[b_addr[3:0]];
      if (ga && a_we) ref_mem[a_addr[3:0]] = a_wdata;
      if (gb && b_we) ref_mem[b_addr[3:0]] = b_wdata;
      if (ga) last = 0;
      if (gb) last = 1;
      if (owner == 0) begin
        if (ga && a_lock) begin owner = 1; age = 1; end
        else if (gb && b_lock) begin owner = 2; age = 1; end
      end else if ((owner == 1 && ga && !a_lock) || (owner == 2 && gb && !b_lock)) begin
        owner = 0;
      end else if (age == LOCK_MAX) begin
        last  = owner - 1;
        owner = 0;
        e_to  = 1;
        n_to++;
      end else begin
        age++;
      end
      a_done = ga;
      b_done = gb;
    end
    @(negedge clk);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    $display("[TB] random traffic saw %0d forced releases", n_to);
  endtask

  initial begin
    reset  = 1'b0;
    pre_we = 1'b0; pre_addr = 0; pre_data = 0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_lock_rmw();
    test_timeout();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
